// File: rtl/ov5640_pkg.sv
// rtl/ov5640_pkg.sv - OV5640 power-up types and constants; fast-sim macro OV5640_PWRUP_FAST_SIM_EN
package ov5640_pkg;

    typedef enum logic [1:0] {
        S_PWDN = 2'd0,
        S_RST  = 2'd1,
        S_INIT = 2'd2,
        S_DONE = 2'd3
    } pwrup_state_t;

    localparam int CLK_FREQ_HZ     = 50_000_000;
    localparam int DEF_PWDN_CYCLES = 300_000;
    localparam int DEF_RST_CYCLES  = 100_000;
    localparam int DEF_INIT_CYCLES = 1_050_000;
    localparam int FAST_SIM_DIV    = 1000;

    // Cycle count actually loaded into the delay timer for a given parameter value.
    // Fast-sim shrinks every delay by FAST_SIM_DIV but never below one cycle.
    function automatic int eff_cycles(input int n);
`ifdef OV5640_PWRUP_FAST_SIM_EN
        return ((n / FAST_SIM_DIV) < 1) ? 1 : (n / FAST_SIM_DIV);
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/ov5640_delay_timer.sv
// rtl/ov5640_delay_timer.sv - reloadable delay counter pulsing expire at count == limit
module ov5640_delay_timer #(
    parameter int CNT_W = 21
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit    = (r_cnt == i_limit);
    assign o_expire = w_hit & ~i_clear;

    // Count up each clock; wrap to zero on expiry so the next state starts fresh, hold zero while cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ov5640_powerup.sv
// rtl/ov5640_powerup.sv - OV5640 PWDN/RESETB power-up sequencer; fast-sim macro OV5640_PWRUP_FAST_SIM_EN
module ov5640_powerup
    import ov5640_pkg::*;
#(
    parameter int PWDN_CYCLES = DEF_PWDN_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int CNT_W       = 21
) (
    input  logic sysclk,
    input  logic rst_n,
    output logic coms_pwdn,
    output logic coms_reset,
    output logic done
);

    localparam int PWDN_EFF = eff_cycles(PWDN_CYCLES);
    localparam int RST_EFF  = eff_cycles(RST_CYCLES);
    localparam int INIT_EFF = eff_cycles(INIT_CYCLES);

    localparam logic [CNT_W-1:0] PWDN_LIM = CNT_W'(PWDN_EFF - 1);
    localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_EFF - 1);
    localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_EFF - 1);

    // A zero-length state cannot be expressed by the counter, and the limit must fit in CNT_W bits.
    generate
        if (PWDN_CYCLES < 1 || RST_CYCLES < 1 || INIT_CYCLES < 1) begin : g_bad_cycles
            $error("ov5640_powerup: cycle parameters must be >= 1");
        end
        if ((longint'(PWDN_EFF) - 1) >= (longint'(1) << CNT_W) ||
            (longint'(RST_EFF)  - 1) >= (longint'(1) << CNT_W) ||
            (longint'(INIT_EFF) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
            $error("ov5640_powerup: CNT_W too narrow for cycle parameters");
        end
    endgenerate

    pwrup_state_t     r_state;
    pwrup_state_t     w_state_nxt;
    logic [CNT_W-1:0] w_limit;
    logic             w_expire;
    logic             w_clear;
    logic             w_pwdn_nxt;
    logic             w_reset_nxt;
    logic             w_done_nxt;
    logic             r_pwdn;
    logic             r_reset;
    logic             r_done;

    assign w_clear = (r_state == S_DONE);

    // Select the delay for the current state; the timer reloads it as soon as the state changes.
    always_comb begin
        w_limit = INIT_LIM;
        case (r_state)
            S_PWDN:  w_limit = PWDN_LIM;
            S_RST:   w_limit = RST_LIM;
            default: w_limit = INIT_LIM;
        endcase
    end

    ov5640_delay_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .i_clk    (sysclk),
        .i_rst_n  (rst_n),
        .i_clear  (w_clear),
        .i_limit  (w_limit),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= S_PWDN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Advance one state per timer expiry; S_DONE is terminal.
    always_comb begin
        w_state_nxt = r_state;
        if (w_expire) begin
            case (r_state)
                S_PWDN:  w_state_nxt = S_RST;
                S_RST:   w_state_nxt = S_INIT;
                S_INIT:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_DONE;
            endcase
        end
    end

    // Pin levels decoded from the next state so the registered pins change on the same edge as the state.
    always_comb begin
        w_pwdn_nxt  = 1'b1;
        w_reset_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_PWDN: begin
                w_pwdn_nxt  = 1'b1;
                w_reset_nxt = 1'b0;
            end
            S_RST: begin
                w_pwdn_nxt  = 1'b0;
                w_reset_nxt = 1'b0;
            end
            S_INIT: begin
                w_pwdn_nxt  = 1'b0;
                w_reset_nxt = 1'b1;
            end
            default: begin
                w_pwdn_nxt  = 1'b0;
                w_reset_nxt = 1'b1;
                w_done_nxt  = 1'b1;
            end
        endcase
    end

    // Output registers keep the sensor pins free of decode glitches.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_pwdn  <= 1'b1;
            r_reset <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pwdn  <= w_pwdn_nxt;
            r_reset <= w_reset_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign coms_pwdn  = r_pwdn;
    assign coms_reset = r_reset;
    assign done       = r_done;

endmodule

// File: tb/tb_ov5640_powerup.sv
// tb/tb_ov5640_powerup.sv - self-checking bench for ov5640_powerup
module tb_ov5640_powerup;

    localparam int EP = 30;
    localparam int ER = 10;
    localparam int EI = 45;
    localparam int TOTAL = EP + ER + EI;

`ifdef OV5640_PWRUP_FAST_SIM_EN
    localparam int PA = 30000;
    localparam int RA = 10000;
    localparam int IA = 45000;
    localparam int PB = 1000;
`else
    localparam int PA = EP;
    localparam int RA = ER;
    localparam int IA = EI;
    localparam int PB = 1;
`endif

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic a_pwdn, a_reset, a_done;
    logic b_pwdn, b_reset, b_done;

    int n     = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #10 sysclk = ~sysclk;

    ov5640_powerup #(
        .PWDN_CYCLES(PA), .RST_CYCLES(RA), .INIT_CYCLES(IA), .CNT_W(16)
    ) u_dut (
        .sysclk(sysclk), .rst_n(rst_n),
        .coms_pwdn(a_pwdn), .coms_reset(a_reset), .done(a_done)
    );

    ov5640_powerup #(
        .PWDN_CYCLES(PB), .RST_CYCLES(PB), .INIT_CYCLES(PB), .CNT_W(4)
    ) u_dut_min (
        .sysclk(sysclk), .rst_n(rst_n),
        .coms_pwdn(b_pwdn), .coms_reset(b_reset), .done(b_done)
    );

    // Pin levels t released edges after reset: pwdn drops at P, reset rises at P+R, done at P+R+I.
    function automatic logic [2:0] model(input int t, input int p, input int r, input int i);
        return {(t < p), (t >= p + r), (t >= p + r + i)};
    endfunction

    function automatic logic [5:0] expected(input int t);
        return {model(t, EP, ER, EI), model(t, 1, 1, 1)};
    endfunction

    function automatic logic [5:0] observed();
        return {a_pwdn, a_reset, a_done, b_pwdn, b_reset, b_done};
    endfunction

    task automatic tick(input logic rv);
        rst_n = rv;
        @(posedge sysclk);
        if (rv) n++;
        else n = 0;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        logic [5:0] got;
        logic [5:0] exp;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0);
            got = observed();
            exp = 6'b100_100;
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset cycle=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_sequence();
        logic [5:0] got;
        logic [5:0] exp;
        logic [5:0] prev;
        int chg[6];
        for (int j = 0; j < 6; j++) chg[j] = 0;
        tick(1'b0);
        prev = observed();
        for (int k = 0; k < TOTAL + 200; k++) begin
            tick(1'b1);
            got = observed();
            exp = expected(n);
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL sequence n=%0d got=%b exp=%b", n, got, exp);
            end
            for (int j = 0; j < 6; j++) if (got[j] !== prev[j]) chg[j]++;
            prev = got;
        end
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (chg[j] != 1) begin
                n_err++;
                $display("FAIL glitch bit=%0d changes=%0d exp=1", j, chg[j]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [5:0] got;
        logic [5:0] exp;
        int rp;
        int len;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) rp = EP + ER / 2;
            else if (it == 1) rp = TOTAL + 3;
            else rp = $urandom_range(0, TOTAL + 5);
            len = (it == 0) ? 1 : $urandom_range(1, 3);
            tick(1'b0);
            for (int k = 0; k < rp + len + TOTAL + 10; k++) begin
                tick((k >= rp && k < rp + len) ? 1'b0 : 1'b1);
                got = observed();
                exp = expected(n);
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL mid_reset it=%0d rp=%0d k=%0d got=%b exp=%b", it, rp, k, got, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got;
        logic [5:0] exp;
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
            got = observed();
            exp = expected(n);
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL back_to_back k=%0d n=%0d got=%b exp=%b", k, n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
